slide_pot_sequencer: RTL and testbench

- Sits between the SPI master driving the ADC128S slide-pot A2D and the equalizer's band-gain/volume registers.
- Round-robins six ADC channels (LP, B1, B2, B3, HP, VOLUME) and returns one 12-bit setting per channel.
- Each channel is read with the ADC128S two-frame protocol: frame 1 selects the channel, frame 2 returns its conversion.
- Holds the last good value per channel and strobes once after each full sweep.

---
 rtl/slide_pot_sequencer.sv | 153 +++++++++++++++
 tb/tb_slide_pot_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slide_pot_sequencer.sv
// Round-robin reader of six ADC128S slide-pot channels using the two-frame
// protocol; holds the last good conversion per channel and strobes per sweep.
module slide_pot_sequencer #(
    parameter logic [15:0] SWEEP_GAP = 16'd2048,
    parameter logic [15:0] TIMEOUT   = 16'd1024,
    parameter logic [2:0]  CH_LP     = 3'd1,
    parameter logic [2:0]  CH_B1     = 3'd0,
    parameter logic [2:0]  CH_B2     = 3'd4,
    parameter logic [2:0]  CH_B3     = 3'd2,
    parameter logic [2:0]  CH_HP     = 3'd3,
    parameter logic [2:0]  CH_VOL    = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] VOLUME,
    output logic        sweep_done,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_WAIT_SEL,
        S_RD,
        S_WAIT_RD,
        S_NEXT
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd5;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic [2:0]  w_chan;
    logic [15:0] r_gap;
    logic [15:0] r_wait_cnt;
    logic        w_in_wait;
    logic        w_wait_hit;
    logic        r_wrt;
    logic [15:0] r_cmd;
    logic        r_sweep_done;
    logic        r_terr;
    logic [11:0] r_pot [0:5];

    assign w_in_wait  = (r_state == S_WAIT_SEL) || (r_state == S_WAIT_RD);
    // Widened compare so the wait gives up on the TIMEOUT-th cycle in the state.
    assign w_wait_hit = ({1'b0, r_wait_cnt} + 17'd1) >= {1'b0, TIMEOUT};

    always_comb begin
        w_idx_next = r_idx;
        if (r_state == S_NEXT) begin
            w_idx_next = (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end
    end

    always_comb begin
        w_chan = CH_LP;
        unique case (w_idx_next)
            3'd0:    w_chan = CH_LP;
            3'd1:    w_chan = CH_B1;
            3'd2:    w_chan = CH_B2;
            3'd3:    w_chan = CH_B3;
            3'd4:    w_chan = CH_HP;
            3'd5:    w_chan = CH_VOL;
            default: w_chan = CH_LP;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (en && (r_gap == '0)) w_next = S_SEL;
            S_SEL:      w_next = S_WAIT_SEL;
            S_WAIT_SEL: begin
                if (spi_done)        w_next = S_RD;
                else if (w_wait_hit) w_next = S_NEXT;
            end
            S_RD:       w_next = S_WAIT_RD;
            S_WAIT_RD:  if (spi_done || w_wait_hit) w_next = S_NEXT;
            S_NEXT:     w_next = (r_idx == LAST_IDX) ? S_IDLE : S_SEL;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_gap        <= '0;
            r_wait_cnt   <= '0;
            r_wrt        <= 1'b0;
            r_cmd        <= '0;
            r_sweep_done <= 1'b0;
            r_terr       <= 1'b0;
            for (int unsigned i = 0; i < 6; i++) begin
                r_pot[i] <= '0;
            end
        end else begin
            r_state      <= w_next;
            r_idx        <= w_idx_next;
            r_wrt        <= (w_next == S_SEL) || (w_next == S_RD);
            r_sweep_done <= (r_state == S_NEXT) && (r_idx == LAST_IDX);

            if (w_next == S_SEL) begin
                r_cmd <= {2'b00, w_chan, 11'h000};
            end

            if ((r_state == S_NEXT) && (r_idx == LAST_IDX)) begin
                r_gap <= SWEEP_GAP;
            end else if ((r_state == S_IDLE) && (r_gap != '0)) begin
                r_gap <= r_gap - 16'd1;
            end

            if ((r_state == S_SEL) || (r_state == S_RD)) begin
                r_wait_cnt <= '0;
            end else if (w_in_wait) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end

            if (w_in_wait && !spi_done && w_wait_hit) begin
                r_terr <= 1'b1;
            end

            // Frame 1 data belongs to the previously selected channel; only frame 2 is kept.
            if ((r_state == S_WAIT_RD) && spi_done) begin
                r_pot[r_idx] <= spi_rd[11:0];
            end
        end
    end

    assign spi_wrt     = r_wrt;
    assign spi_cmd     = r_cmd;
    assign sweep_done  = r_sweep_done;
    assign timeout_err = r_terr;
    assign POT_LP      = r_pot[0];
    assign POT_B1      = r_pot[1];
    assign POT_B2      = r_pot[2];
    assign POT_B3      = r_pot[3];
    assign POT_HP      = r_pot[4];
    assign VOLUME      = r_pot[5];

endmodule

// File: tb/tb_slide_pot_sequencer.sv
// Bench for slide_pot_sequencer: transaction-level ADC model with per-cycle
// comparison plus directed literal checks of sweeps, timeout, gap and reset.
module tb_slide_pot_sequencer;

    localparam int DLY = 40;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rd = 16'h0000;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME;
    logic        sweep_done;
    logic        timeout_err;

    slide_pot_sequencer #(
        .SWEEP_GAP(16'd100),
        .TIMEOUT  (16'd1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spi_wrt    (spi_wrt),
        .spi_cmd    (spi_cmd),
        .spi_done   (spi_done),
        .spi_rd     (spi_rd),
        .POT_LP     (POT_LP),
        .POT_B1     (POT_B1),
        .POT_B2     (POT_B2),
        .POT_B3     (POT_B3),
        .POT_HP     (POT_HP),
        .VOLUME     (VOLUME),
        .sweep_done (sweep_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Sweep order LP, B1, B2, B3, HP, VOL mapped to ADC channel numbers.
    logic [2:0]  CHS [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

    // Model state
    logic [11:0] m_pot [6] = '{default: 12'h000};
    logic        m_terr = 1'b0;
    int          sd_cd = 0;
    logic        upd_pend = 1'b0;
    int          upd_idx = 0;
    logic [11:0] upd_val = '0;
    logic        to_apply = 1'b0;
    int          to_idx = 0;

    // Transaction tracking / ADC responder
    int          seq_idx = 0;
    int          seq_fr = 0;
    logic        pend = 1'b0;
    int          cd = 0;
    logic        to_pend = 1'b0;
    int          to_cd = 0;
    logic [15:0] cur_cmd = '0;
    logic        prev_wrt = 1'b0;
    int          cyc = 0;
    int          wrt_cnt = 0;
    int          sd_seen = 0;
    int          last_sd_cyc = 0;
    logic        await_first = 1'b0;
    int          gap_meas = -1;
    logic [15:0] last_cmd = '0;
    logic [15:0] cmd_log [12];
    logic        data_mode = 1'b0;
    logic        sup_en = 1'b0;
    int          sup_idx = 0;
    int          sup_fr = 0;

    function automatic logic [11:0] rd_val(input int idx);
        if (data_mode) return 12'h123;
        return 12'((int'(CHS[idx]) + 1) * 256);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) m_pot[i] = 12'h000;
            m_terr   = 1'b0;
            sd_cd    = 0;
            upd_pend = 1'b0;
            to_apply = 1'b0;
        end else begin
            if (upd_pend) begin
                m_pot[upd_idx] = upd_val;
                if (upd_idx == 5) sd_cd = 2;
                upd_pend = 1'b0;
            end
            if (to_apply) begin
                m_terr = 1'b1;
                if (to_idx == 5) sd_cd = 2;
                to_apply = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        chk("POT_LP", {4'h0, POT_LP}, {4'h0, m_pot[0]});
        chk("POT_B1", {4'h0, POT_B1}, {4'h0, m_pot[1]});
        chk("POT_B2", {4'h0, POT_B2}, {4'h0, m_pot[2]});
        chk("POT_B3", {4'h0, POT_B3}, {4'h0, m_pot[3]});
        chk("POT_HP", {4'h0, POT_HP}, {4'h0, m_pot[4]});
        chk("VOLUME", {4'h0, VOLUME}, {4'h0, m_pot[5]});
        chk("timeout_err", {15'h0, timeout_err}, {15'h0, m_terr});
        chk("sweep_done", {15'h0, sweep_done}, {15'h0, (sd_cd == 1)});
        if (sd_cd > 0) sd_cd--;
        chk("spi_wrt_pulse", {15'h0, spi_wrt & prev_wrt}, 16'h0000);
        prev_wrt = spi_wrt;
        if (sweep_done) begin
            sd_seen++;
            last_sd_cyc = cyc;
            await_first = 1'b1;
        end
        if (rst) begin
            seq_idx  = 0;
            seq_fr   = 0;
            pend     = 1'b0;
            to_pend  = 1'b0;
            spi_done = 1'b0;
        end else begin
            spi_done = 1'b0;
            if (pend || to_pend) chk("spi_cmd_hold", spi_cmd, cur_cmd);
            if (pend) begin
                cd--;
                if (cd == 0) begin
                    pend     = 1'b0;
                    spi_done = 1'b1;
                    if (seq_fr == 0) begin
                        spi_rd = {4'hA, 12'hFFF};
                        seq_fr = 1;
                    end else begin
                        spi_rd   = {4'hA, rd_val(seq_idx)};
                        upd_pend = 1'b1;
                        upd_idx  = seq_idx;
                        upd_val  = rd_val(seq_idx);
                        seq_fr   = 0;
                        seq_idx  = (seq_idx == 5) ? 0 : seq_idx + 1;
                    end
                end
            end
            if (to_pend) begin
                to_cd++;
                if (to_cd == TMO) begin
                    to_pend  = 1'b0;
                    to_apply = 1'b1;
                    to_idx   = seq_idx;
                    seq_fr   = 0;
                    seq_idx  = (seq_idx == 5) ? 0 : seq_idx + 1;
                end
            end
            if (spi_wrt) begin
                cur_cmd = {2'b00, CHS[seq_idx], 11'h000};
                chk("spi_cmd", spi_cmd, cur_cmd);
                last_cmd = spi_cmd;
                if (wrt_cnt < 12) cmd_log[wrt_cnt] = spi_cmd;
                if (await_first) begin
                    gap_meas    = cyc - last_sd_cyc;
                    await_first = 1'b0;
                end
                wrt_cnt++;
                if (sup_en && sup_idx == seq_idx && sup_fr == seq_fr) begin
                    sup_en  = 1'b0;
                    to_pend = 1'b1;
                    to_cd   = 0;
                end else begin
                    pend = 1'b1;
                    cd   = DLY;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sd(input int maxc);
        int s0 = sd_seen;
        int n = 0;
        while (sd_seen == s0 && n < maxc) begin
            step();
            n++;
        end
        n_chk++;
        if (sd_seen == s0) begin
            n_fail++;
            $display("FAIL wait_sweep_done: no pulse within %0d cycles", maxc);
        end
    endtask

    task automatic wait_wrt(input int maxc);
        int w0 = wrt_cnt;
        int n = 0;
        while (wrt_cnt == w0 && n < maxc) begin
            step();
            n++;
        end
        n_chk++;
        if (wrt_cnt == w0) begin
            n_fail++;
            $display("FAIL wait_spi_wrt: no request within %0d cycles", maxc);
        end
    endtask

    logic [15:0] exp_cmds [6] = '{16'h0800, 16'h0000, 16'h2000, 16'h1000, 16'h1800, 16'h3800};

    initial begin
        int w0;
        int n;
        repeat (3) step();
        chk("rst_POT_LP", {4'h0, POT_LP}, 16'h0000);
        chk("rst_VOLUME", {4'h0, VOLUME}, 16'h0000);
        chk("rst_spi_wrt", {15'h0, spi_wrt}, 16'h0000);
        chk("rst_spi_cmd", spi_cmd, 16'h0000);
        chk("rst_sweep_done", {15'h0, sweep_done}, 16'h0000);
        chk("rst_timeout_err", {15'h0, timeout_err}, 16'h0000);

        // Sweep 1: channel-coded data
        rst = 1'b0;
        en  = 1'b1;
        wait_sd(2000);
        chk("s1_wrt_count", 16'(wrt_cnt), 16'd12);
        chk("s1_POT_LP", {4'h0, POT_LP}, 16'h0200);
        chk("s1_POT_B1", {4'h0, POT_B1}, 16'h0100);
        chk("s1_POT_B2", {4'h0, POT_B2}, 16'h0500);
        chk("s1_POT_B3", {4'h0, POT_B3}, 16'h0300);
        chk("s1_POT_HP", {4'h0, POT_HP}, 16'h0400);
        chk("s1_VOLUME", {4'h0, VOLUME}, 16'h0800);
        for (int i = 0; i < 12; i++) chk("s1_cmd_log", cmd_log[i], exp_cmds[i / 2]);

        // Sweep 2: frame 1 returns FFF, frame 2 returns 123
        data_mode = 1'b1;
        w0 = wrt_cnt;
        wait_wrt(300);
        chk("gap_after_sweep1", 16'(gap_meas), 16'd101);
        wait_sd(2000);
        chk("s2_wrt_count", 16'(wrt_cnt - w0), 16'd12);
        chk("s2_POT_B2", {4'h0, POT_B2}, 16'h0123);
        chk("s2_VOLUME", {4'h0, VOLUME}, 16'h0123);

        // Sweep 3: B2 second frame never completes
        data_mode = 1'b0;
        sup_idx   = 2;
        sup_fr    = 1;
        sup_en    = 1'b1;
        w0 = wrt_cnt;
        wait_wrt(300);
        chk("gap_after_sweep2", 16'(gap_meas), 16'd101);
        wait_sd(4000);
        chk("s3_wrt_count", 16'(wrt_cnt - w0), 16'd12);
        chk("s3_timeout_err", {15'h0, timeout_err}, 16'h0001);
        chk("s3_POT_B2_kept", {4'h0, POT_B2}, 16'h0123);
        chk("s3_POT_B3", {4'h0, POT_B3}, 16'h0300);
        chk("s3_POT_LP", {4'h0, POT_LP}, 16'h0200);

        // Sweep 4: en dropped after first request; sweep must still finish
        w0 = wrt_cnt;
        wait_wrt(300);
        en = 1'b0;
        wait_sd(2000);
        chk("s4_wrt_count", 16'(wrt_cnt - w0), 16'd12);
        w0 = wrt_cnt;
        repeat (300) step();
        chk("s4_idle_no_wrt", 16'(wrt_cnt - w0), 16'd0);

        // Reset while B3 is in its second-frame wait
        en = 1'b1;
        n = 0;
        while (!(seq_idx == 3 && seq_fr == 1 && pend) && n < 2000) begin
            step();
            n++;
        end
        n_chk++;
        if (!(seq_idx == 3 && seq_fr == 1 && pend)) begin
            n_fail++;
            $display("FAIL wait_B3_rd: not reached within 2000 cycles");
        end
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("mrst_POT_LP", {4'h0, POT_LP}, 16'h0000);
        chk("mrst_POT_B2", {4'h0, POT_B2}, 16'h0000);
        chk("mrst_VOLUME", {4'h0, VOLUME}, 16'h0000);
        chk("mrst_timeout_err", {15'h0, timeout_err}, 16'h0000);
        chk("mrst_spi_wrt", {15'h0, spi_wrt}, 16'h0000);
        rst = 1'b0;
        wait_wrt(50);
        chk("mrst_first_cmd", last_cmd, 16'h0800);
        repeat (100) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
